// File: rtl/generate_q_pkg.sv
// Shared encodings for the online-divider quotient collector.
// Holds the digit codes, the default alignment offset and the store-word field layout.
package generate_q_pkg;

    typedef enum logic [1:0] {
        Q_ZERO = 2'b00,
        Q_NEG  = 2'b01,
        Q_POS  = 2'b10,
        Q_INV  = 2'b11
    } q_digit_t;

    localparam int DEFAULT_ALIGN_OFFSET = 5;

    // A store word is {plus, minus, conv}; each field is UNROLLING bits wide and is
    // selected out of a packed [2:0][UNROLLING-1:0] vector by this index.
    typedef enum logic [1:0] {
        F_CONV  = 2'd0,
        F_MINUS = 2'd1,
        F_PLUS  = 2'd2
    } q_field_t;

endpackage

// File: rtl/generate_q_otf_buf_ram.sv
// Simple dual-port store with one write port and one registered, write-first read port.
// Latency: one cycle from rd_en to rd_vld/rd_dat; backpressure: none, every request is served.
module q_digit_ram #(
    parameter int WIDTH      = 192,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_dat,
    output logic                  rd_vld
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            rd_dat <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_dat <= (wr_en && (wr_addr == rd_addr)) ? wr_dat : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/generate_q_otf_buf.sv
// Collects signed quotient digits with on-the-fly conversion and commits aligned words to a store.
// Latency: state updates on the digit's edge, reads return one cycle after rd_en; backpressure: none.
module generate_q_otf_buf
    import generate_q_pkg::*;
#(
    parameter int UNROLLING    = 64,
    parameter int ADDR_WIDTH   = 7,
    parameter int SHIFT_WIDTH  = 11,
    parameter int ALIGN_OFFSET = DEFAULT_ALIGN_OFFSET
) (
    input  logic                   clk,
    input  logic                   asyn_reset,
    input  logic                   enable,
    input  logic                   refresh,
    input  logic [1:0]             q_value,
    input  logic                   commit,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [SHIFT_WIDTH-1:0] shift_cnt,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_valid,
    output logic [UNROLLING-1:0]   q_plus_rd,
    output logic [UNROLLING-1:0]   q_minus_rd,
    output logic [UNROLLING-1:0]   q_conv_rd,
    output logic [SHIFT_WIDTH-1:0] digit_cnt,
    output logic                   overflow,
    output logic                   invalid
);

    logic [UNROLLING-1:0] acc_p, acc_m, q_reg, qm_reg;
    logic [UNROLLING-1:0] base_p, base_m, base_q, base_qm;
    logic [UNROLLING-1:0] nxt_p, nxt_m, nxt_q, nxt_qm;
    logic                 d_pos, d_neg, d_inv, cnt_full;
    logic [SHIFT_WIDTH:0] shamt;
    logic [2:0][UNROLLING-1:0] wr_word, rd_word;

    always_comb begin
        d_pos    = (q_value == Q_POS);
        d_neg    = (q_value == Q_NEG);
        d_inv    = (q_value == Q_INV);
        cnt_full = (digit_cnt == SHIFT_WIDTH'(UNROLLING));

        base_p  = refresh ? '0 : acc_p;
        base_m  = refresh ? '0 : acc_m;
        base_q  = refresh ? '0 : q_reg;
        base_qm = refresh ? '1 : qm_reg;

        nxt_p  = acc_p;
        nxt_m  = acc_m;
        nxt_q  = q_reg;
        nxt_qm = qm_reg;
        // An invalid code behaves exactly like a zero digit.
        if (enable) begin
            nxt_p = {base_p[UNROLLING-2:0], d_pos};
            nxt_m = {base_m[UNROLLING-2:0], d_neg};
            if (d_pos) begin
                nxt_q  = {base_q[UNROLLING-2:0], 1'b1};
                nxt_qm = {base_q[UNROLLING-2:0], 1'b0};
            end else if (d_neg) begin
                nxt_q  = {base_qm[UNROLLING-2:0], 1'b1};
                nxt_qm = {base_qm[UNROLLING-2:0], 1'b0};
            end else begin
                nxt_q  = {base_q[UNROLLING-2:0], 1'b0};
                nxt_qm = {base_qm[UNROLLING-2:0], 1'b1};
            end
        end
    end

    // Commit sees the post-update word, so a digit in the same cycle is stored.
    always_comb begin
        shamt = {1'b0, shift_cnt} + (SHIFT_WIDTH + 1)'(ALIGN_OFFSET);
        if (shamt >= (SHIFT_WIDTH + 1)'(UNROLLING)) begin
            wr_word = '0;
        end else begin
            wr_word[F_PLUS]  = nxt_p << shamt;
            wr_word[F_MINUS] = nxt_m << shamt;
            wr_word[F_CONV]  = nxt_q << shamt;
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            acc_p     <= '0;
            acc_m     <= '0;
            q_reg     <= '0;
            qm_reg    <= '0;
            digit_cnt <= '0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
        end else if (enable) begin
            acc_p  <= nxt_p;
            acc_m  <= nxt_m;
            q_reg  <= nxt_q;
            qm_reg <= nxt_qm;
            if (refresh) begin
                digit_cnt <= SHIFT_WIDTH'(1);
                overflow  <= 1'b0;
                invalid   <= d_inv;
            end else begin
                digit_cnt <= cnt_full ? digit_cnt : digit_cnt + SHIFT_WIDTH'(1);
                overflow  <= overflow | cnt_full;
                invalid   <= invalid | d_inv;
            end
        end
    end

    q_digit_ram #(
        .WIDTH      (3 * UNROLLING),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .wr_en      (commit),
        .wr_addr    (wr_addr),
        .wr_dat     (wr_word),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_dat     (rd_word),
        .rd_vld     (rd_valid)
    );

    assign q_plus_rd  = rd_word[F_PLUS];
    assign q_minus_rd = rd_word[F_MINUS];
    assign q_conv_rd  = rd_word[F_CONV];

endmodule

// File: tb/tb_generate_q_otf_buf.sv
// Bench for generate_q_otf_buf at UNROLLING=8, ALIGN_OFFSET=0: directed table, reset sequence, random vs model.
module tb_generate_q_otf_buf;

    localparam int U  = 8;
    localparam int AW = 4;
    localparam int SW = 11;

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic          enable, refresh, commit, rd_en;
    logic [1:0]    q_value;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [SW-1:0] shift_cnt;
    logic          rd_valid, overflow, invalid;
    logic [U-1:0]  q_plus_rd, q_minus_rd, q_conv_rd;
    logic [SW-1:0] digit_cnt;

    generate_q_otf_buf #(
        .UNROLLING    (U),
        .ADDR_WIDTH   (AW),
        .SHIFT_WIDTH  (SW),
        .ALIGN_OFFSET (0)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (enable),
        .refresh    (refresh),
        .q_value    (q_value),
        .commit     (commit),
        .wr_addr    (wr_addr),
        .shift_cnt  (shift_cnt),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .q_plus_rd  (q_plus_rd),
        .q_minus_rd (q_minus_rd),
        .q_conv_rd  (q_conv_rd),
        .digit_cnt  (digit_cnt),
        .overflow   (overflow),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int en, rf, q, cm, wa, sc, rd, ra;
        int cnt, ovf, inv, vld, chk, p, m, c;
    } vec_t;

    vec_t tbl[$];

    // Reference model: word values as plain integers modulo 2**U, store as arrays.
    int mp, mm, mc, mcnt;
    bit movf, minv;
    int st_p [1 << AW];
    int st_m [1 << AW];
    int st_c [1 << AW];
    bit st_w [1 << AW];
    bit evld, eknown;
    int ep, em, ec;

    function automatic vec_t mk(int en, int rf, int q, int cm, int wa, int sc, int rd, int ra,
                                int cnt, int ovf, int inv, int vld, int chk, int p, int m, int c);
        vec_t v;
        v.en = en; v.rf = rf; v.q = q; v.cm = cm; v.wa = wa; v.sc = sc; v.rd = rd; v.ra = ra;
        v.cnt = cnt; v.ovf = ovf; v.inv = inv; v.vld = vld; v.chk = chk; v.p = p; v.m = m; v.c = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp = 0; mm = 0; mc = 0; mcnt = 0; movf = 0; minv = 0;
        evld = 0; eknown = 1; ep = 0; em = 0; ec = 0;
    endtask

    task automatic model_step(input int en, input int rf, input int q, input int cm,
                              input int wa, input int sc, input int rd, input int ra);
        int d;
        d = (q == 2) ? 1 : (q == 1) ? -1 : 0;
        if (en != 0) begin
            if (rf != 0) begin
                mp = 0; mm = 0; mc = 0; mcnt = 0; movf = 0; minv = 0;
            end else if (mcnt == U) begin
                movf = 1;
            end
            if (q == 3) minv = 1;
            mp = (mp * 2 + ((d == 1) ? 1 : 0)) & 255;
            mm = (mm * 2 + ((d == -1) ? 1 : 0)) & 255;
            mc = (mc * 2 + d) & 255;
            mcnt = (mcnt < U) ? mcnt + 1 : U;
        end
        if (cm != 0) begin
            st_p[wa] = (sc >= U) ? 0 : (mp << sc) & 255;
            st_m[wa] = (sc >= U) ? 0 : (mm << sc) & 255;
            st_c[wa] = (sc >= U) ? 0 : (mc << sc) & 255;
            st_w[wa] = 1;
        end
        evld = (rd != 0);
        if (rd != 0) begin
            eknown = st_w[ra];
            ep = st_p[ra]; em = st_m[ra]; ec = st_c[ra];
        end
    endtask

    // Called right after a falling edge; returns after the next falling edge.
    task automatic apply(input int en, input int rf, input int q, input int cm,
                         input int wa, input int sc, input int rd, input int ra);
        enable    = (en != 0);
        refresh   = (rf != 0);
        q_value   = 2'(q);
        commit    = (cm != 0);
        wr_addr   = AW'(wa);
        shift_cnt = SW'(sc);
        rd_en     = (rd != 0);
        rd_addr   = AW'(ra);
        @(posedge clk);
        model_step(en, rf, q, cm, wa, sc, rd, ra);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " digit_cnt"}, 64'(digit_cnt), 64'(mcnt));
        check({tag, " overflow"}, 64'(overflow), 64'(movf));
        check({tag, " invalid"}, 64'(invalid), 64'(minv));
        check({tag, " rd_valid"}, 64'(rd_valid), 64'(evld));
        if (eknown) begin
            check({tag, " q_plus_rd"}, 64'(q_plus_rd), 64'(ep));
            check({tag, " q_minus_rd"}, 64'(q_minus_rd), 64'(em));
            check({tag, " q_conv_rd"}, 64'(q_conv_rd), 64'(ec));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " digit_cnt"}, 64'(digit_cnt), 64'd0);
        check({tag, " overflow"}, 64'(overflow), 64'd0);
        check({tag, " invalid"}, 64'(invalid), 64'd0);
        check({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, " q_plus_rd"}, 64'(q_plus_rd), 64'd0);
        check({tag, " q_minus_rd"}, 64'(q_minus_rd), 64'd0);
        check({tag, " q_conv_rd"}, 64'(q_conv_rd), 64'd0);
    endtask

    initial begin
        bit need_ref;
        int en, rf, q;
        vec_t v;

        asyn_reset = 1'b1;
        enable = 0; refresh = 0; q_value = 0; commit = 0;
        wr_addr = 0; shift_cnt = 0; rd_en = 0; rd_addr = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            st_w[i] = 0; st_p[i] = 0; st_m[i] = 0; st_c[i] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("in_reset");
        asyn_reset = 1'b0;

        // en rf q cm wa sc rd ra | cnt ovf inv vld chk p m c
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0, 0,0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,2,0,0,0,0,0, 1,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 2,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,1,0,0,0,0,0, 3,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,2,1,3,0,0,0, 4,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,3, 4,0,0,1,1, 'h09,'h02,'h07));
        tbl.push_back(mk(0,0,0,1,4,3,0,0, 4,0,0,0,1, 'h09,'h02,'h07));
        tbl.push_back(mk(0,0,0,0,0,0,1,4, 4,0,0,1,1, 'h48,'h10,'h38));
        tbl.push_back(mk(0,0,0,1,6,8,1,6, 4,0,0,1,1, 0,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0,0, 1,0,0,0,1, 0,0,0));
        tbl.push_back(mk(1,0,1,1,5,0,1,5, 2,0,0,1,1, 'h00,'h03,'hFD));
        tbl.push_back(mk(0,0,0,0,0,0,1,3, 2,0,0,1,1, 'h09,'h02,'h07));
        tbl.push_back(mk(1,1,3,0,0,0,0,0, 1,0,1,0,1, 'h09,'h02,'h07));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1,0,2,0,0,0,0,0, 2 + i,0,1,0,1, 'h09,'h02,'h07));
        tbl.push_back(mk(1,0,2,0,0,0,0,0, 8,1,1,0,1, 'h09,'h02,'h07));
        tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,0,1, 'h09,'h02,'h07));

        foreach (tbl[i]) begin
            v = tbl[i];
            apply(v.en, v.rf, v.q, v.cm, v.wa, v.sc, v.rd, v.ra);
            check($sformatf("row%0d digit_cnt", i), 64'(digit_cnt), 64'(v.cnt));
            check($sformatf("row%0d overflow", i), 64'(overflow), 64'(v.ovf));
            check($sformatf("row%0d invalid", i), 64'(invalid), 64'(v.inv));
            check($sformatf("row%0d rd_valid", i), 64'(rd_valid), 64'(v.vld));
            if (v.chk != 0) begin
                check($sformatf("row%0d q_plus_rd", i), 64'(q_plus_rd), 64'(v.p));
                check($sformatf("row%0d q_minus_rd", i), 64'(q_minus_rd), 64'(v.m));
                check($sformatf("row%0d q_conv_rd", i), 64'(q_conv_rd), 64'(v.c));
            end
        end

        // Asynchronous reset mid-word with a live read result on the outputs.
        apply(1,1,2,0,0,0,0,0);
        apply(1,0,1,0,0,0,1,3);
        check("pre_reset rd_valid", 64'(rd_valid), 64'd1);
        enable = 0; refresh = 0; commit = 0; rd_en = 0;
        #2 asyn_reset = 1'b1;
        #1 check_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        asyn_reset = 1'b0;
        // Committing straight after reset must store an all-zero working word.
        apply(0,0,0,1,7,0,1,7);
        check_model("post_reset_commit");

        need_ref = 1;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) < 7) ? 1 : 0;
            rf = (need_ref || ($urandom_range(0, 9) == 0)) ? 1 : 0;
            if (en != 0 && rf != 0) need_ref = 0;
            q = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            apply(en, rf, q, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
